// File: rtl/pac_man_pkg.sv
// pac_man_pkg: shared grid constants, types and the adjacency rule for Pac-Man movement.
// PAC_MAN_TUNNEL_WRAP_EN makes col 0 and col COLS-1 of the same row adjacent (side tunnel).
package pac_man_pkg;
    localparam int GRID_COLS  = 32;
    localparam int GRID_ROWS  = 30;
    localparam int NUM_BLOCKS = GRID_COLS * GRID_ROWS;

    typedef logic [9:0] block_t;

    typedef enum logic [1:0] {IDLE, READ, DECIDE} mover_state_t;

    function automatic logic is_adjacent(block_t a, block_t b);
        logic [5:0] ar, ac, br, bc;
        logic       adj;
        // 6-bit fields so col 31 + 1 cannot alias col 0
        ar  = {1'b0, a[9:5]};
        ac  = {1'b0, a[4:0]};
        br  = {1'b0, b[9:5]};
        bc  = {1'b0, b[4:0]};
        adj = (ar == br && (ac == bc + 6'd1 || bc == ac + 6'd1)) ||
              (ac == bc && (ar == br + 6'd1 || br == ar + 6'd1));
`ifdef PAC_MAN_TUNNEL_WRAP_EN
        adj = adj || (ar == br && ((ac == 6'd0 && bc == 6'(GRID_COLS - 1)) ||
                                   (bc == 6'd0 && ac == 6'(GRID_COLS - 1))));
`endif
        return adj;
    endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: free-running move tick; pending is set on each wrap and held until consumed.
module move_tick_gen #(
    parameter int TICK_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic consume_i,
    output logic pending_o
);
    localparam int CW = $clog2(TICK_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic          wrap;

    assign wrap      = cnt_q == CW'(TICK_CYCLES - 1);
    assign pending_o = pending_q;

    // a wrap coinciding with consume wins so no tick is lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= wrap ? '0 : cnt_q + 1'b1;
            pending_q <= wrap | (pending_q & ~consume_i);
        end
    end
endmodule

// File: rtl/pac_man_mover.sv
// pac_man_mover: accepts a requested block, checks range/adjacency/wall, commits on the move tick.
// PAC_MAN_TUNNEL_WRAP_EN enables the side tunnel between col 0 and col COLS-1.
module pac_man_mover
    import pac_man_pkg::*;
#(
    parameter int COLS        = 32,
    parameter int ROWS        = 30,
    parameter int START_BLOCK = 495,
    parameter int TICK_CYCLES = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  block_t req_block_i,
    input  logic   req_valid_i,
    output logic   req_ready_o,
    output block_t wall_addr_o,
    input  logic   wall_rd_data_i,
    output block_t curr_block_o,
    output logic   moved_o,
    output logic   blocked_o,
    output logic   pellet_clr_o,
    output block_t pellet_addr_o
);
    mover_state_t state_q;
    block_t       req_q, curr_q, pellet_addr_q;
    logic         moved_q, blocked_q;
    logic         pending, legal;

    move_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .consume_i(state_q == DECIDE),
        .pending_o(pending)
    );

    // rows are the upper field, so a linear bound equals a row-field bound for power-of-two COLS
    assign legal = (req_q < 10'(COLS * ROWS)) && is_adjacent(curr_q, req_q) && !wall_rd_data_i;

    assign req_ready_o   = (state_q == IDLE) && pending;
    assign wall_addr_o   = req_q;
    assign curr_block_o  = curr_q;
    assign moved_o       = moved_q;
    assign blocked_o     = blocked_q;
    assign pellet_clr_o  = moved_q;
    assign pellet_addr_o = pellet_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            req_q         <= '0;
            curr_q        <= block_t'(START_BLOCK);
            pellet_addr_q <= '0;
            moved_q       <= 1'b0;
            blocked_q     <= 1'b0;
        end else begin
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid_i && pending) begin
                    req_q   <= req_block_i;
                    state_q <= READ;
                end
                READ: state_q <= DECIDE;
                DECIDE: begin
                    state_q <= IDLE;
                    if (req_q != curr_q) begin
                        if (legal) begin
                            curr_q        <= req_q;
                            pellet_addr_q <= req_q;
                            moved_q       <= 1'b1;
                        end else begin
                            blocked_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pac_man_mover.sv
// tb_pac_man_mover: scoreboard bench; expected outcomes are queued at accept and checked after commit.
module tb_pac_man_mover;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req_block = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] wall_addr;
    logic       wall_rd_data = 1'b0;
    logic [9:0] curr_block;
    logic       moved, blocked, pellet_clr;
    logic [9:0] pellet_addr;

    typedef struct {
        logic [9:0] blk;
        logic [9:0] curr;
        logic       mv;
        logic       bl;
    } exp_t;

    exp_t       sb[$];
    logic       wall_mem[0:1023];
    int         model_curr = 495;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) wall_rd_data <= wall_mem[wall_addr];

    pac_man_mover dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_block_i   (req_block),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .wall_addr_o   (wall_addr),
        .wall_rd_data_i(wall_rd_data),
        .curr_block_o  (curr_block),
        .moved_o       (moved),
        .blocked_o     (blocked),
        .pellet_clr_o  (pellet_clr),
        .pellet_addr_o (pellet_addr)
    );

    function automatic logic model_legal(int cur, int req, logic w);
        int  cr, cc, rr, rc, dr, dc;
        logic adj;
        cr  = cur / 32;
        cc  = cur % 32;
        rr  = req / 32;
        rc  = req % 32;
        dr  = (rr > cr) ? rr - cr : cr - rr;
        dc  = (rc > cc) ? rc - cc : cc - rc;
        adj = (rr == cr && dc == 1) || (rc == cc && dr == 1);
`ifdef PAC_MAN_TUNNEL_WRAP_EN
        adj = adj || (rr == cr && dc == 31);
`endif
        return (rr < 30) && adj && !w;
    endfunction

    task automatic do_move(input int blk, input logic wall);
        int   n;
        exp_t e, g;
        wall_mem[blk] = wall;
        req_block = 10'(blk);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!req_ready) begin
            n_bad++;
            $display("FAIL ready_timeout blk=%0d: req_ready=%b after %0d cycles, required 1", blk, req_ready, n);
            req_valid = 1'b0;
            return;
        end
        e.blk  = 10'(blk);
        e.mv   = (blk != model_curr) && model_legal(model_curr, blk, wall);
        e.bl   = (blk != model_curr) && !e.mv;
        e.curr = e.mv ? 10'(blk) : 10'(model_curr);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (wall_addr !== 10'(blk) || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL read_phase blk=%0d: wall_addr=%0d ready=%b, required %0d 0", blk, wall_addr, req_ready, blk);
        end
        @(negedge clk);
        @(negedge clk);
        g = sb.pop_front();
        n_cmp++;
        if (curr_block !== g.curr || moved !== g.mv || blocked !== g.bl || pellet_clr !== g.mv ||
            (g.mv && pellet_addr !== g.blk)) begin
            n_bad++;
            $display("FAIL commit blk=%0d: curr=%0d mv=%b bl=%b pc=%b pa=%0d, required curr=%0d mv=%b bl=%b pc=%b pa=%0d",
                     g.blk, curr_block, moved, blocked, pellet_clr, pellet_addr, g.curr, g.mv, g.bl, g.mv, g.blk);
        end
        model_curr = int'(g.curr);
        @(negedge clk);
        n_cmp++;
        if (moved !== 1'b0 || blocked !== 1'b0 || pellet_clr !== 1'b0 || curr_block !== g.curr) begin
            n_bad++;
            $display("FAIL pulse_width blk=%0d: mv=%b bl=%b pc=%b curr=%0d, required 0 0 0 %0d",
                     g.blk, moved, blocked, pellet_clr, curr_block, g.curr);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 1024; i++) wall_mem[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_curr = 495;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (curr_block !== 10'd495 || moved || blocked || pellet_clr || req_ready !== 1'b0 ||
            wall_addr !== 10'd0 || pellet_addr !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_values: curr=%0d mv=%b bl=%b pc=%b rdy=%b wa=%0d pa=%0d, required 495 0 0 0 0 0 0",
                     curr_block, moved, blocked, pellet_clr, req_ready, wall_addr, pellet_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_early: req_ready=%b after 3 cycles, required 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_first_tick: req_ready=%b after 4 cycles, required 1", req_ready);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || curr_block !== 10'd495) begin
            n_bad++;
            $display("FAIL ready_hold: req_ready=%b curr=%0d, required 1 495", req_ready, curr_block);
        end
    endtask

    task automatic test_moves();
        do_move(496, 1'b1);
        do_move(463, 1'b0);
        do_move(463, 1'b0);
        do_move(497, 1'b0);
        do_move(975, 1'b0);
        do_move(464, 1'b0);
        do_move(495, 1'b0);
    endtask

    task automatic test_row_wrap_and_range();
        reset_dut();
        for (int c = 14; c >= 0; c--) do_move(480 + c, 1'b0);
        do_move(479, 1'b0);
        do_move(511, 1'b0);
        reset_dut();
        for (int r = 16; r <= 29; r++) do_move(r * 32 + 15, 1'b0);
        do_move(975, 1'b0);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        do_move(463, 1'b0);
        wait_ready_then_accept(431);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (curr_block !== 10'd495 || req_ready !== 1'b0 || moved || blocked) begin
            n_bad++;
            $display("FAIL reset_mid: curr=%0d rdy=%b mv=%b bl=%b, required 495 0 0 0", curr_block, req_ready, moved, blocked);
        end
        model_curr = 495;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reaccept_early: req_ready=%b, required 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reaccept_tick: req_ready=%b, required 1", req_ready);
        end
        do_move(431, 1'b0);
        do_move(463, 1'b0);
    endtask

    task automatic wait_ready_then_accept(input int blk);
        int n;
        req_block = 10'(blk);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) wall_mem[i] = 1'b0;
        test_reset();
        test_moves();
        test_row_wrap_and_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
